// File: rtl/multiple_checker_seq.sv
// ---------------------------------------------------------------------------
// multiple_checker_seq
//
// Sequential divisibility checker. Accepts an unsigned number and a divisor
// select, runs a bit-serial restoring division (one quotient bit per cycle,
// MSB first) and presents quotient, remainder and an "is a multiple" flag
// behind a valid/ready output handshake. Two saturating counters track how
// many results were delivered and how many of them were exact multiples.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       operand offered
//   in_ready       block idle and able to accept an operand
//   number         dividend, unsigned, WIDTH bits
//   sel            divisor select, divisor = sel + 2
//   out_valid      result fields valid
//   out_ready      consumer takes the result
//   ismultiple     remainder == 0
//   quotient       number / divisor
//   remainder      number mod divisor, SEL_W+1 bits
//   total_count    results delivered since reset/clear (saturating)
//   multiple_count delivered results with ismultiple = 1 (saturating)
//   clear          synchronous zeroing of both counters
// ---------------------------------------------------------------------------
module multiple_checker_seq #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] number,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ismultiple,
    output logic [WIDTH-1:0] quotient,
    output logic [SEL_W:0]   remainder,
    output logic [CNT_W-1:0] total_count,
    output logic [CNT_W-1:0] multiple_count,
    input  logic             clear
);

    // Divisor reaches 2^SEL_W + 1, so it and the remainder need SEL_W+1 bits;
    // the shifted trial value needs one more.
    localparam int DIV_W = SEL_W + 1;
    localparam int T_W   = SEL_W + 2;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] num_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] rem_work;
    logic [WIDTH-1:0] q_work;
    logic [IDX_W-1:0] idx;

    logic [T_W-1:0]   t;
    logic [DIV_W-1:0] rem_sub;
    logic [DIV_W-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             qbit;
    logic             out_hs;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_hs    = (state == S_DONE) && out_ready;

    // One restoring-division step. When t >= divisor the difference is
    // smaller than the divisor, so dropping t's top bit before subtracting
    // still yields the exact remainder in DIV_W bits.
    always_comb begin
        t        = {rem_work, num_r[idx]};
        qbit     = (t >= {1'b0, div_r});
        rem_sub  = t[DIV_W-1:0] - div_r;
        rem_next = qbit ? rem_sub : t[DIV_W-1:0];
        q_next   = q_work;
        q_next[idx] = qbit;
    end

    // Control FSM and datapath. The working registers are separate from the
    // result outputs so the previous result stays visible while the next
    // operand is being processed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            num_r      <= '0;
            div_r      <= '0;
            rem_work   <= '0;
            q_work     <= '0;
            idx        <= '0;
            quotient   <= '0;
            remainder  <= '0;
            ismultiple <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        num_r    <= number;
                        div_r    <= {1'b0, sel} + DIV_W'(2);
                        rem_work <= '0;
                        q_work   <= '0;
                        idx      <= IDX_W'(WIDTH - 1);
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_work <= rem_next;
                    q_work   <= q_next;
                    if (idx == '0) begin
                        quotient   <= q_next;
                        remainder  <= rem_next;
                        ismultiple <= (rem_next == '0);
                        state      <= S_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Delivery statistics; clear wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total_count    <= '0;
            multiple_count <= '0;
        end else if (out_hs) begin
            if (total_count != '1)
                total_count <= total_count + CNT_W'(1);
            if (ismultiple && (multiple_count != '1))
                multiple_count <= multiple_count + CNT_W'(1);
        end
    end

endmodule
